glyph_reader: RTL and testbench
===============================

GLYPH_READER -- requirements
Module: glyph_reader

Interface
REQ-001 Parameter ERR_NIBBLE, default 4'h0: nibble value reported for an unmatched glyph.
REQ-002 Parameter REQUIRE_START, default 1: when 1, the block discards pixels until pix_start; when 0, it starts counting from reset.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pix_valid  input  1  pixel present on pix_data.
REQ-006 pix_data  input  1  pixel value: 1 = lit.
REQ-007 pix_start  input  1  qualified by pix_valid; marks the first pixel of a byte frame.
REQ-008 pix_ready  output  1  block accepts a pixel this cycle.
REQ-009 byte_valid  output  1  decoded byte held on byte_out.
REQ-010 byte_ready  input  1  consumer takes the byte.
REQ-011 byte_out  output  8  decoded byte: [7:4] from left glyph, [3:0] from right glyph.
REQ-012 byte_err  output  2  bit1 = left glyph unmatched, bit0 = right glyph unmatched; valid with byte_valid.
REQ-013 err_count  output  8  saturating count of bytes with any unmatched glyph.

Function
REQ-014 A pixel is accepted on a cycle where pix_valid && pix_ready.
REQ-015 A frame is 30 accepted pixels: left glyph bits 14..0, then right glyph bits 14..0, MSB first; bits 14:12 are the top row.
REQ-016 The state machine has two states: HUNT and RUN; the 5-bit pixel counter runs 0..29 in RUN.
REQ-017 In HUNT, pix_ready=1; accepted pixels without pix_start are dropped; an accepted pixel with pix_start is stored as left bit 14, counter=1, next state RUN.
REQ-018 In RUN, an accepted pixel with pix_start restarts the frame: the pixel becomes left bit 14, counter=1, and partial data is discarded without error.
REQ-019 In RUN, pix_ready = (counter != 29) || !byte_valid || byte_ready.
REQ-020 On acceptance of pixel 29, both glyphs (including the incoming pixel) are decoded and registered into byte_out/byte_err; byte_valid=1 the next cycle (1-cycle latency); counter=0.
REQ-021 After pixel 29: next state HUNT if REQUIRE_START=1, else RUN with counter=0.
REQ-022 Decode table (15-bit hex): 0=7B6F 1=4924 2=79CF 3=79E7 4=5BE4 5=73E7 6=73EF 7=7924 8=7BEF 9=7BE7 A=7BED B=13EF C=724F D=49EF E=738F F=73C9.
REQ-023 An exact match yields the listed nibble; no match yields ERR_NIBBLE and sets the glyph's byte_err bit.
REQ-024 byte_valid stays high, with byte_out/byte_err stable, until byte_valid && byte_ready; it then clears unless a new byte is loaded in the same cycle, in which case it stays 1 with the new data.
REQ-025 err_count increments by 1 on each load with byte_err != 0 and saturates at 8'hFF.
REQ-026 byte_ready while byte_valid=0 has no effect.

Reset
REQ-027 Reset forces: state = HUNT if REQUIRE_START=1 (else RUN), counter=0, shift register=0, byte_valid=0, byte_out=8'h00, byte_err=2'b00, err_count=8'h00; pix_ready=1 after reset.
REQ-028 Reset mid-frame or with a byte pending discards all data; no byte_valid pulse follows reset.

Verification
REQ-029 Start frame for left=79E7, right=7BED, byte_ready=1 -> byte_valid one cycle after pixel 29, byte_out=8'h3A, byte_err=00, err_count=0.
REQ-030 Left=7FFF, right=4924 -> byte_out=8'h01 (ERR_NIBBLE=0), byte_err=10, err_count=1; 300 such frames -> err_count=8'hFF.
REQ-031 byte_ready=0, two frames back to back -> pix_ready low only at pixel 29 of frame 2; first byte held stable; raise byte_ready -> byte 1 and then byte 2 delivered in order, none lost.
REQ-032 pix_start asserted at pixel 12 of a frame, then 30 valid pixels for 0x5E -> exactly one byte 8'h5E, byte_err=00.
REQ-033 Pixels sent without pix_start (REQUIRE_START=1) -> no byte_valid; reset asserted at pixel 20 -> byte_valid=0, err_count=0, state HUNT.
REQ-034 Random pix_valid gaps during a 0xC7 frame -> byte_out=8'hC7; all 256 byte values round-trip through the REQ-022 table.

Source files
------------

// File: rtl/glyph_reader.sv
// glyph_reader: deserialises 30-pixel frames of two 3x5 glyphs into a decoded byte
module glyph_reader #(
  parameter logic [3:0] ERR_NIBBLE    = 4'h0,
  parameter bit         REQUIRE_START = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_valid,
  input  logic       pix_data,
  input  logic       pix_start,
  output logic       pix_ready,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic [7:0] byte_out,
  output logic [1:0] byte_err,
  output logic [7:0] err_count
);
  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [0:0] IDLE = REQUIRE_START ? HUNT : RUN;
  localparam logic [14:0] GLYPH [16] = '{
    15'h7B6F, 15'h4924, 15'h79CF, 15'h79E7, 15'h5BE4, 15'h73E7, 15'h73EF, 15'h7924,
    15'h7BEF, 15'h7BE7, 15'h7BED, 15'h13EF, 15'h724F, 15'h49EF, 15'h738F, 15'h73C9
  };
  logic [0:0]  state;
  logic [4:0]  cnt;
  logic [28:0] sh;
  logic        acc, load;
  logic [29:0] frame;
  logic [4:0]  dl, dr;
  // {unmatched, nibble}
  function automatic logic [4:0] decode(input logic [14:0] g);
    logic [4:0] r;
    r = {1'b1, ERR_NIBBLE};
    for (int i = 0; i < 16; i++)
      if (g == GLYPH[i]) r = {1'b0, 4'(i)};
    return r;
  endfunction
  assign pix_ready = state == HUNT || cnt != 5'd29 || !byte_valid || byte_ready;
  assign acc       = pix_valid && pix_ready;
  assign load      = acc && !pix_start && state == RUN && cnt == 5'd29;
  assign frame     = {sh, pix_data};
  assign dl        = decode(frame[29:15]);
  assign dr        = decode(frame[14:0]);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      sh         <= '0;
      byte_valid <= 1'b0;
      byte_out   <= 8'h00;
      byte_err   <= 2'b00;
      err_count  <= 8'h00;
    end else begin
      if (acc && pix_start) begin
        state <= RUN;
        cnt   <= 5'd1;
        sh    <= {28'b0, pix_data};
      end else if (load) begin
        state <= IDLE;
        cnt   <= 5'd0;
        sh    <= '0;
      end else if (acc && state == RUN) begin
        cnt <= cnt + 5'd1;
        sh  <= {sh[27:0], pix_data};
      end
      if (load) begin
        byte_valid <= 1'b1;
        byte_out   <= {dl[3:0], dr[3:0]};
        byte_err   <= {dl[4], dr[4]};
        if ((dl[4] || dr[4]) && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end else if (byte_ready) begin
        byte_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_glyph_reader.sv
// tb_glyph_reader: directed scoreboard bench for glyph_reader
`define CHK(tag, obs, exp) begin total++; assert ((obs) === (exp)) else begin bad++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end end
module tb_glyph_reader;
  logic       clk = 1'b0, reset = 1'b1;
  logic       pix_valid = 1'b0, pix_data = 1'b0, pix_start = 1'b0, byte_ready = 1'b0;
  logic       pix_ready, byte_valid;
  logic [7:0] byte_out, err_count;
  logic [1:0] byte_err;
  int         total = 0, bad = 0, stalls = 0, cur_idx = 0, emodel = 0;
  logic [9:0] q[$];
  localparam logic [14:0] G [16] = '{
    15'h7B6F, 15'h4924, 15'h79CF, 15'h79E7, 15'h5BE4, 15'h73E7, 15'h73EF, 15'h7924,
    15'h7BEF, 15'h7BE7, 15'h7BED, 15'h13EF, 15'h724F, 15'h49EF, 15'h738F, 15'h73C9
  };

  glyph_reader dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_start(pix_start), .pix_ready(pix_ready), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .byte_out(byte_out), .byte_err(byte_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  always begin
    @(negedge clk);
    #2;
    if (!reset && byte_valid) begin
      if (q.size() == 0) begin
        total++; bad++;
        $error("FAIL spurious_byte observed=%0h expected=none", {byte_err, byte_out});
      end else begin
        `CHK("byte", {byte_err, byte_out}, q[0])
        if (byte_ready) void'(q.pop_front());
      end
    end
  end

  task automatic push(input logic [9:0] e);
    q.push_back(e);
    if (e[9:8] != 2'b00 && emodel != 255) emodel++;
  endtask

  task automatic send(input logic d, input logic s, input bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    pix_valid = 1'b1; pix_data = d; pix_start = s;
    #1;
    n = 0;
    while (!pix_ready && n < 100) begin
      stalls++;
      `CHK("stall_idx", cur_idx, 29)
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $error("FAIL accept_timeout observed=%0d expected=<100", n);
    end
    @(negedge clk);
    pix_valid = 1'b0; pix_start = 1'b0;
  endtask

  task automatic frame(input logic [14:0] l, input logic [14:0] r, input logic [9:0] e, input bit gaps);
    logic [29:0] f;
    f = {l, r};
    for (int i = 0; i < 30; i++) begin
      cur_idx = i;
      if (i == 29) push(e);
      send(f[29-i], i == 0, gaps);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    `CHK("drain", q.size(), 0)
    `CHK("err_count", err_count, 8'(emodel))
  endtask

  initial begin
    repeat (2) @(negedge clk);
    `CHK("rst_valid", byte_valid, 1'b0)
    `CHK("rst_out", byte_out, 8'h00)
    `CHK("rst_err", byte_err, 2'b00)
    `CHK("rst_cnt", err_count, 8'h00)
    `CHK("rst_ready", pix_ready, 1'b1)
    reset = 1'b0;
    byte_ready = 1'b1;
    @(negedge clk);
    frame(15'h79E7, 15'h7BED, {2'b00, 8'h3A}, 1'b0);
    `CHK("latency", byte_valid, 1'b1)
    drain();
    frame(15'h7FFF, 15'h4924, {2'b10, 8'h01}, 1'b0);
    drain();
    `CHK("err_one", err_count, 8'h01)
    frame(15'h4924, 15'h0000, {2'b01, 8'h10}, 1'b0);
    drain();
    for (int k = 0; k < 298; k++) frame(15'h7FFF, 15'h4924, {2'b10, 8'h01}, 1'b0);
    drain();
    `CHK("err_sat", err_count, 8'hFF)
    byte_ready = 1'b0;
    stalls = 0;
    frame(G[1], G[2], {2'b00, 8'h12}, 1'b0);
    `CHK("no_stall_f1", stalls, 0)
    fork
      frame(G[3], G[4], {2'b00, 8'h34}, 1'b0);
      begin
        int n;
        n = 0;
        while (stalls == 0 && n < 2000) begin
          @(negedge clk);
          n++;
        end
        `CHK("stall_seen", stalls > 0, 1'b1)
        repeat (3) @(negedge clk);
        byte_ready = 1'b1;
      end
    join
    drain();
    for (int i = 0; i < 12; i++) send(1'($urandom_range(0, 1)), i == 0, 1'b0);
    frame(G[5], G[14], {2'b00, 8'h5E}, 1'b0);
    drain();
    for (int i = 0; i < 40; i++) send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    `CHK("nostart_valid", byte_valid, 1'b0)
    byte_ready = 1'b0;
    frame(G[9], G[8], {2'b00, 8'h98}, 1'b0);
    for (int i = 0; i < 20; i++) send(1'($urandom_range(0, 1)), i == 0, 1'b0);
    reset = 1'b1;
    q.delete();
    emodel = 0;
    @(negedge clk);
    reset = 1'b0;
    `CHK("mid_rst_valid", byte_valid, 1'b0)
    `CHK("mid_rst_cnt", err_count, 8'h00)
    `CHK("mid_rst_state", dut.state, 1'b0)
    `CHK("mid_rst_ready", pix_ready, 1'b1)
    repeat (5) @(negedge clk);
    `CHK("post_rst_valid", byte_valid, 1'b0)
    byte_ready = 1'b1;
    frame(G[12], G[7], {2'b00, 8'hC7}, 1'b1);
    drain();
    for (int v = 0; v < 256; v++) frame(G[v >> 4], G[v & 15], {2'b00, 8'(v)}, 1'b0);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
